// File: rtl/wb_ddr_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_ddr_arbiter_if
// Wishbone classic bus bundle used on every port of wb_ddr_arbiter.
//   master modport : drives cyc/stb/we/sel/adr/dat_w, receives dat_r/ack/err
//   slave  modport : receives cyc/stb/we/sel/adr/dat_w, drives dat_r/ack/err
// Parameter adr_width sets the address bus width.
// -----------------------------------------------------------------------------
interface wb_ddr_arbiter_if #(
   parameter int adr_width = 32
) ();
   logic                 cyc;
   logic                 stb;
   logic                 we;
   logic [3:0]           sel;
   logic [adr_width-1:0] adr;
   logic [31:0]          dat_w;
   logic [31:0]          dat_r;
   logic                 ack;
   logic                 err;

   modport master (
      output cyc, stb, we, sel, adr, dat_w,
      input  dat_r, ack, err
   );

   modport slave (
      input  cyc, stb, we, sel, adr, dat_w,
      output dat_r, ack, err
   );
endinterface

// File: rtl/wb_ddr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_ddr_arbiter
// Two-master Wishbone arbiter sharing the DDR controller slave port between the
// LM32 instruction bus (m0) and data bus (m1). One owner at a time, round-robin
// on contention, grant held for the whole CYC of the owner.
//
// Ports
//   clk    in  system clock, all logic on posedge
//   reset  in  synchronous, active-high
//   m0     wb_ddr_arbiter_if.slave   LM32 I-bus
//   m1     wb_ddr_arbiter_if.slave   LM32 D-bus
//   s      wb_ddr_arbiter_if.master  DDR controller port
//
// Parameters
//   adr_width  address width on all ports
//   timeout    stalled cycles before the watchdog forces an error
//
// Build option
//   WB_ARB_TIMEOUT_EN  when defined, a slave stall of timeout cycles ends the
//                      owner's cycle with a one-cycle err and drops the grant.
//                      When undefined a hung slave keeps the grant forever.
// -----------------------------------------------------------------------------
module wb_ddr_arbiter #(
   parameter int adr_width = 32,
   parameter int timeout   = 64
) (
   input  logic             clk,
   input  logic             reset,
   wb_ddr_arbiter_if.slave  m0,
   wb_ddr_arbiter_if.slave  m1,
   wb_ddr_arbiter_if.master s
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_last_gnt;
   logic                  w_last_gnt_nxt;
   logic                  w_to;

   logic                  w_cyc;
   logic                  w_stb;
   logic                  w_we;
   logic [3:0]            w_sel;
   logic [adr_width-1:0]  w_adr;
   logic [31:0]           w_dat_w;
   logic                  w_ack0;
   logic                  w_err0;
   logic                  w_ack1;
   logic                  w_err1;

   // A watchdog threshold below 2 cannot represent a counted stall.
   if (timeout < 2) begin : g_timeout_check
      $error("wb_ddr_arbiter: timeout must be at least 2");
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_last_gnt <= 1'b1;   // m0 wins the first contention
      end else begin
         r_state    <= w_state_nxt;
         r_last_gnt <= w_last_gnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_last_gnt_nxt = r_last_gnt;
      case (r_state)
         ST_IDLE: begin
            if (m0.cyc && !m1.cyc)      w_state_nxt = ST_GNT0;
            else if (m1.cyc && !m0.cyc) w_state_nxt = ST_GNT1;
            else if (m0.cyc && m1.cyc)  w_state_nxt = r_last_gnt ? ST_GNT0 : ST_GNT1;
         end
         // Release always passes through IDLE, giving one dead cycle between owners.
         ST_GNT0: begin
            if (!m0.cyc || w_to) begin
               w_state_nxt    = ST_IDLE;
               w_last_gnt_nxt = 1'b0;
            end
         end
         ST_GNT1: begin
            if (!m1.cyc || w_to) begin
               w_state_nxt    = ST_IDLE;
               w_last_gnt_nxt = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Bus mux is purely combinational from the state, so the data phase adds no latency.
   always_comb begin
      w_cyc   = 1'b0;
      w_stb   = 1'b0;
      w_we    = 1'b0;
      w_sel   = '0;
      w_adr   = '0;
      w_dat_w = '0;
      w_ack0  = 1'b0;
      w_err0  = 1'b0;
      w_ack1  = 1'b0;
      w_err1  = 1'b0;
      case (r_state)
         ST_GNT0: begin
            w_cyc   = m0.cyc & ~w_to;
            w_stb   = m0.stb & ~w_to;
            w_we    = m0.we;
            w_sel   = m0.sel;
            w_adr   = m0.adr;
            w_dat_w = m0.dat_w;
            w_ack0  = s.ack;
            w_err0  = s.err | w_to;
         end
         ST_GNT1: begin
            w_cyc   = m1.cyc & ~w_to;
            w_stb   = m1.stb & ~w_to;
            w_we    = m1.we;
            w_sel   = m1.sel;
            w_adr   = m1.adr;
            w_dat_w = m1.dat_w;
            w_ack1  = s.ack;
            w_err1  = s.err | w_to;
         end
         default: ;
      endcase
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int               CNT_W   = $clog2(timeout) + 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(timeout - 1);

   logic [CNT_W-1:0] r_cnt;

   // Counts cycles the owner's strobe has gone unanswered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_state == ST_IDLE || s.ack || s.err || w_to) begin
         r_cnt <= '0;
      end else if (w_cyc && w_stb) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign w_to = (r_state != ST_IDLE) && (r_cnt == TO_LAST);
`else
   assign w_to = 1'b0;
`endif

   assign s.cyc    = w_cyc;
   assign s.stb    = w_stb;
   assign s.we     = w_we;
   assign s.sel    = w_sel;
   assign s.adr    = w_adr;
   assign s.dat_w  = w_dat_w;

   // Read data is broadcast; each master qualifies it with its own ack.
   assign m0.dat_r = s.dat_r;
   assign m1.dat_r = s.dat_r;
   assign m0.ack   = w_ack0;
   assign m0.err   = w_err0;
   assign m1.ack   = w_ack1;
   assign m1.err   = w_err1;

endmodule
